// File: rtl/ctrl_pkg.sv
// Shared encodings for the decode stage: opcode/funct constants, datapath
// control codes, the packed control word and the fixed bubble/trap/exception words.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BGEZ = 5'd1;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NEQ = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_GEZ = 6'b111001;
    localparam logic [5:0] ALU_GTZ = 6'b111111;

    localparam logic [2:0] PC_SEQ    = 3'b000;
    localparam logic [2:0] PC_BRANCH = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_JR     = 3'b011;
    localparam logic [2:0] PC_IRQ    = 3'b100;
    localparam logic [2:0] PC_EXC    = 3'b101;

    localparam logic [1:0] RD_RD = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;
    localparam logic [1:0] RD_XP = 2'b11;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    typedef struct packed {
        logic [2:0]  pc_src;
        logic [1:0]  reg_dst;
        logic [1:0]  mem_to_reg;
        logic        reg_wr;
        logic        alu_src1;
        logic        alu_src2;
        logic        sign;
        logic        mem_wr;
        logic        mem_rd;
        logic        ext_op;
        logic        lu_op;
        logic [5:0]  alu_fun;
        logic [25:0] jt;
        logic [5:0]  opcode;
    } ctrl_t;

    typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} fsm_state_t;

    // Traps and exceptions both save PC+4 into $26 and redirect the PC.
    function automatic ctrl_t redirect_word(input logic [2:0] src);
        ctrl_t w;
        w            = '0;
        w.pc_src     = src;
        w.reg_dst    = RD_XP;
        w.mem_to_reg = M2R_PC;
        w.reg_wr     = 1'b1;
        return w;
    endfunction

    localparam ctrl_t CTRL_BUBBLE = '0;
    localparam ctrl_t CTRL_TRAP   = redirect_word(PC_IRQ);
    localparam ctrl_t CTRL_EXC    = redirect_word(PC_EXC);

    localparam int unsigned CAUSE_NONE     = 0;
    localparam int unsigned CAUSE_IRQ_BASE = 1;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Bundle of IF/ID inputs and ID/EX control outputs of the decode stage.
interface ctrl_decode_stage_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4,
    parameter int CAUSE_W = 4
);
    logic               if_valid;
    logic [31:0]        instr;
    logic [XLEN-1:0]    pc_plus;
    logic [NUM_IRQ-1:0] irq;
    logic               stall;
    logic               flush;

    logic               ex_valid;
    logic [2:0]         pc_src;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               reg_wr;
    logic               alu_src1;
    logic               alu_src2;
    logic               sign;
    logic               mem_wr;
    logic               mem_rd;
    logic               ext_op;
    logic               lu_op;
    logic [5:0]         alu_fun;
    logic [25:0]        jt;
    logic [5:0]         opcode;
    logic [XLEN-1:0]    ex_pc_plus;
    logic [CAUSE_W-1:0] cause;
    logic [NUM_IRQ-1:0] irq_ack;

    modport master (
        output if_valid, instr, pc_plus, irq, stall, flush,
        input  ex_valid, pc_src, reg_dst, mem_to_reg, reg_wr, alu_src1, alu_src2,
               sign, mem_wr, mem_rd, ext_op, lu_op, alu_fun, jt, opcode,
               ex_pc_plus, cause, irq_ack
    );

    modport slave (
        input  if_valid, instr, pc_plus, irq, stall, flush,
        output ex_valid, pc_src, reg_dst, mem_to_reg, reg_wr, alu_src1, alu_src2,
               sign, mem_wr, mem_rd, ext_op, lu_op, alu_fun, jt, opcode,
               ex_pc_plus, cause, irq_ack
    );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure combinational instruction decoder; flags unsupported encodings and,
// when STRICT_FIELDS is set, encodings with nonzero reserved fields.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter bit STRICT_FIELDS = 1'b1
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        undef_o
);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    ctrl_t      c;
    logic       unknown;
    logic       rsv_nonzero;

    assign op    = instr_i[31:26];
    assign rs    = instr_i[25:21];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];
    assign shamt = instr_i[10:6];
    assign funct = instr_i[5:0];

    always_comb begin
        c           = CTRL_BUBBLE;
        unknown     = 1'b0;
        rsv_nonzero = 1'b0;
        case (op)
            OP_RTYPE: begin
                c.reg_wr    = 1'b1;
                c.reg_dst   = RD_RD;
                rsv_nonzero = (shamt != 5'd0);
                case (funct)
                    FN_SLL:  begin c.alu_src1 = 1'b1; c.alu_fun = ALU_SLL; rsv_nonzero = (rs != 5'd0); end
                    FN_SRL:  begin c.alu_src1 = 1'b1; c.alu_fun = ALU_SRL; rsv_nonzero = (rs != 5'd0); end
                    FN_SRA:  begin c.alu_src1 = 1'b1; c.alu_fun = ALU_SRA; rsv_nonzero = (rs != 5'd0); end
                    FN_JR: begin
                        c.reg_wr    = 1'b0;
                        c.pc_src    = PC_JR;
                        rsv_nonzero = (rt != 5'd0) || (rd != 5'd0) || (shamt != 5'd0);
                    end
                    FN_JALR: begin
                        c.pc_src     = PC_JR;
                        c.mem_to_reg = M2R_PC;
                        rsv_nonzero  = (rt != 5'd0) || (shamt != 5'd0);
                    end
                    FN_ADD:  begin c.alu_fun = ALU_ADD; c.sign = 1'b1; end
                    FN_ADDU: c.alu_fun = ALU_ADD;
                    FN_SUB:  begin c.alu_fun = ALU_SUB; c.sign = 1'b1; end
                    FN_SUBU: c.alu_fun = ALU_SUB;
                    FN_AND:  c.alu_fun = ALU_AND;
                    FN_OR:   c.alu_fun = ALU_OR;
                    FN_XOR:  c.alu_fun = ALU_XOR;
                    FN_NOR:  c.alu_fun = ALU_NOR;
                    FN_SLT:  begin c.alu_fun = ALU_LT; c.sign = 1'b1; end
                    FN_SLTU: c.alu_fun = ALU_LT;
                    default: unknown = 1'b1;
                endcase
            end
            // Branches compare rs against rt or zero; the target offset is sign-extended.
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                c.pc_src = PC_BRANCH;
                c.ext_op = 1'b1;
                c.sign   = 1'b1;
                c.opcode = op;
                case (op)
                    OP_REGIMM: begin c.alu_fun = ALU_GEZ; unknown = (rt != RT_BGEZ); end
                    OP_BEQ:    c.alu_fun = ALU_EQ;
                    OP_BNE:    c.alu_fun = ALU_NEQ;
                    OP_BLEZ:   begin c.alu_fun = ALU_LEZ; rsv_nonzero = (rt != 5'd0); end
                    default:   begin c.alu_fun = ALU_GTZ; rsv_nonzero = (rt != 5'd0); end
                endcase
            end
            OP_J: begin
                c.pc_src = PC_JUMP;
                c.jt     = instr_i[25:0];
            end
            OP_JAL: begin
                c.pc_src     = PC_JUMP;
                c.jt         = instr_i[25:0];
                c.reg_wr     = 1'b1;
                c.reg_dst    = RD_RA;
                c.mem_to_reg = M2R_PC;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI, OP_LW: begin
                c.reg_wr   = 1'b1;
                c.reg_dst  = RD_RT;
                c.alu_src2 = 1'b1;
                c.ext_op   = 1'b1;
                case (op)
                    OP_ADDI:  c.sign = 1'b1;
                    OP_SLTI:  begin c.alu_fun = ALU_LT; c.sign = 1'b1; end
                    OP_SLTIU: c.alu_fun = ALU_LT;
                    OP_ANDI:  begin c.alu_fun = ALU_AND; c.ext_op = 1'b0; end
                    OP_LUI:   begin c.lu_op = 1'b1; c.ext_op = 1'b0; rsv_nonzero = (rs != 5'd0); end
                    OP_LW:    begin c.mem_rd = 1'b1; c.mem_to_reg = M2R_MEM; end
                    default:  c.alu_fun = ALU_ADD;
                endcase
            end
            OP_SW: begin
                c.mem_wr   = 1'b1;
                c.alu_src2 = 1'b1;
                c.ext_op   = 1'b1;
            end
            default: unknown = 1'b1;
        endcase
    end

    assign undef_o = unknown | (STRICT_FIELDS & rsv_nonzero);
    assign ctrl_o  = c;

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: interrupt edge capture and priority, trap-sequencing
// FSM that squashes wrong-path user instructions, and the ID/EX register.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int NUM_IRQ       = 4,
    parameter int CAUSE_W       = 4,
    parameter bit STRICT_FIELDS = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    ctrl_decode_stage_if.slave  bus
);
    ctrl_t              dec_ctrl;
    logic               dec_undef;
    logic               kernel;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] sel_onehot;
    logic [3:0]         sel_idx;
    logic               take_irq;
    fsm_state_t         state_q;
    fsm_state_t         state_d;
    ctrl_t              ctrl_q;
    ctrl_t              ctrl_d;
    logic               ex_valid_q;
    logic               ex_valid_d;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] cause_d;
    logic [NUM_IRQ-1:0] ack_q;
    logic [NUM_IRQ-1:0] ack_d;
    logic [XLEN-1:0]    pc_plus_q;

    ctrl_decode_comb #(.STRICT_FIELDS(STRICT_FIELDS)) u_dec (
        .instr_i (bus.instr),
        .ctrl_o  (dec_ctrl),
        .undef_o (dec_undef)
    );

    assign kernel   = bus.pc_plus[XLEN-1];
    assign irq_rise = bus.irq & ~irq_q;

    // A fresh edge on a line beats the acknowledge that would clear it.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
        assign pending_d[gi] = irq_rise[gi] | (pending_q[gi] & ~ack_d[gi]);
    end

    always_comb begin
        sel_idx    = 4'd0;
        sel_onehot = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                sel_idx    = 4'(k);
                sel_onehot = '0;
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // Kernel code is never interrupted, so reaching here in TRAP implies no take.
    assign take_irq = (pending_q != '0) && !kernel;

    always_comb begin
        ctrl_d     = CTRL_BUBBLE;
        ex_valid_d = 1'b0;
        cause_d    = CAUSE_W'(CAUSE_NONE);
        ack_d      = '0;
        state_d    = state_q;
        if (!bus.flush && !bus.stall && bus.if_valid && (state_q == ST_RUN || kernel)) begin
            state_d    = ST_RUN;
            ex_valid_d = 1'b1;
            if (take_irq) begin
                ctrl_d  = CTRL_TRAP;
                cause_d = CAUSE_W'(sel_idx + 4'(CAUSE_IRQ_BASE));
                ack_d   = sel_onehot;
                state_d = ST_TRAP;
            end else if (dec_undef) begin
                ctrl_d  = CTRL_EXC;
                cause_d = '1;
                state_d = ST_TRAP;
            end else begin
                ctrl_d  = dec_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q      <= '0;
            pending_q  <= '0;
            state_q    <= ST_RUN;
            ctrl_q     <= CTRL_BUBBLE;
            ex_valid_q <= 1'b0;
            cause_q    <= '0;
            ack_q      <= '0;
            pc_plus_q  <= '0;
        end else begin
            irq_q      <= bus.irq;
            pending_q  <= pending_d;
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            ex_valid_q <= ex_valid_d;
            cause_q    <= cause_d;
            ack_q      <= ack_d;
            pc_plus_q  <= bus.pc_plus;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.pc_src     = ctrl_q.pc_src;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.reg_wr     = ctrl_q.reg_wr;
    assign bus.alu_src1   = ctrl_q.alu_src1;
    assign bus.alu_src2   = ctrl_q.alu_src2;
    assign bus.sign       = ctrl_q.sign;
    assign bus.mem_wr     = ctrl_q.mem_wr;
    assign bus.mem_rd     = ctrl_q.mem_rd;
    assign bus.ext_op     = ctrl_q.ext_op;
    assign bus.lu_op      = ctrl_q.lu_op;
    assign bus.alu_fun    = ctrl_q.alu_fun;
    assign bus.jt         = ctrl_q.jt;
    assign bus.opcode     = ctrl_q.opcode;
    assign bus.ex_pc_plus = pc_plus_q;
    assign bus.cause      = cause_q;
    assign bus.irq_ack    = ack_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: decode table plus trap/irq/stall/flush/reset sequences.
module tb_ctrl_decode_stage;

    localparam logic [31:0] PC_USER = 32'h0040_0004;
    localparam logic [31:0] PC_KERN = 32'h8000_0004;
    localparam logic [31:0] I_ADD   = 32'h012A_4020;
    localparam logic [31:0] I_BAD   = 32'h0000_0001;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage_if #(.XLEN(32), .NUM_IRQ(4), .CAUSE_W(4)) ifc ();

    ctrl_decode_stage #(.XLEN(32), .NUM_IRQ(4), .CAUSE_W(4), .STRICT_FIELDS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // {ex_valid, cause, pc_src, reg_dst, mem_to_reg,
    //  {reg_wr,alu_src1,alu_src2,sign,mem_wr,mem_rd,ext_op,lu_op}, alu_fun, opcode, jt}
    function automatic logic [57:0] w(input logic v, input logic [3:0] c, input logic [2:0] pc,
                                      input logic [1:0] rd, input logic [1:0] m2r, input logic [7:0] fl,
                                      input logic [5:0] alu, input logic [5:0] opc, input logic [25:0] jt);
        return {v, c, pc, rd, m2r, fl, alu, opc, jt};
    endfunction

    function automatic logic [57:0] act_word();
        return {ifc.ex_valid, ifc.cause, ifc.pc_src, ifc.reg_dst, ifc.mem_to_reg,
                ifc.reg_wr, ifc.alu_src1, ifc.alu_src2, ifc.sign, ifc.mem_wr, ifc.mem_rd,
                ifc.ext_op, ifc.lu_op, ifc.alu_fun, ifc.opcode, ifc.jt};
    endfunction

    function automatic logic [57:0] trap_w(input logic [3:0] c);
        return w(1'b1, c, 3'b100, 2'b11, 2'b10, 8'h80, 6'h00, 6'h00, 26'h0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] pc);
        ifc.if_valid = 1'b1;
        ifc.instr    = i;
        ifc.pc_plus  = pc;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [57:0] exp;
    } vec_t;

    vec_t        tbl[20];
    logic [57:0] EXC_W;
    logic [57:0] ADD_W;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        EXC_W = w(1'b1, 4'hF, 3'b101, 2'b11, 2'b10, 8'h80, 6'h00, 6'h00, 26'h0);
        ADD_W = w(1'b1, 4'h0, 3'b000, 2'b00, 2'b00, 8'h90, 6'h00, 6'h00, 26'h0);
        tbl[0]  = '{"add",     32'h012A4020, ADD_W};
        tbl[1]  = '{"sll",     32'h00031100, w(1, 0, 3'b000, 2'b00, 2'b00, 8'hC0, 6'h20, 6'h00, 26'h0)};
        tbl[2]  = '{"sub",     32'h00430822, w(1, 0, 3'b000, 2'b00, 2'b00, 8'h90, 6'h01, 6'h00, 26'h0)};
        tbl[3]  = '{"sltu",    32'h00A6202B, w(1, 0, 3'b000, 2'b00, 2'b00, 8'h80, 6'h35, 6'h00, 26'h0)};
        tbl[4]  = '{"jr",      32'h03E00008, w(1, 0, 3'b011, 2'b00, 2'b00, 8'h00, 6'h00, 6'h00, 26'h0)};
        tbl[5]  = '{"jalr",    32'h00A0F809, w(1, 0, 3'b011, 2'b00, 2'b10, 8'h80, 6'h00, 6'h00, 26'h0)};
        tbl[6]  = '{"j",       32'h08100000, w(1, 0, 3'b010, 2'b00, 2'b00, 8'h00, 6'h00, 6'h00, 26'h0100000)};
        tbl[7]  = '{"jal",     32'h0FFFFFFF, w(1, 0, 3'b010, 2'b10, 2'b10, 8'h80, 6'h00, 6'h00, 26'h3FFFFFF)};
        tbl[8]  = '{"beq",     32'h10220004, w(1, 0, 3'b001, 2'b00, 2'b00, 8'h12, 6'h33, 6'h04, 26'h0)};
        tbl[9]  = '{"bgez",    32'h04610008, w(1, 0, 3'b001, 2'b00, 2'b00, 8'h12, 6'h39, 6'h01, 26'h0)};
        tbl[10] = '{"bgtz",    32'h1C800001, w(1, 0, 3'b001, 2'b00, 2'b00, 8'h12, 6'h3F, 6'h07, 26'h0)};
        tbl[11] = '{"addiu",   32'h24C5FFFF, w(1, 0, 3'b000, 2'b01, 2'b00, 8'hA2, 6'h00, 6'h00, 26'h0)};
        tbl[12] = '{"andi",    32'h310700FF, w(1, 0, 3'b000, 2'b01, 2'b00, 8'hA0, 6'h18, 6'h00, 26'h0)};
        tbl[13] = '{"lui",     32'h3C091234, w(1, 0, 3'b000, 2'b01, 2'b00, 8'hA1, 6'h00, 6'h00, 26'h0)};
        tbl[14] = '{"lw",      32'h8FAA0010, w(1, 0, 3'b000, 2'b01, 2'b01, 8'hA6, 6'h00, 6'h00, 26'h0)};
        tbl[15] = '{"sw",      32'hAFAA0010, w(1, 0, 3'b000, 2'b00, 2'b00, 8'h2A, 6'h00, 6'h00, 26'h0)};
        tbl[16] = '{"ori_undef",   32'h34000000, EXC_W};
        tbl[17] = '{"add_shamt",   32'h012A4060, EXC_W};
        tbl[18] = '{"funct01",     32'h00000001, EXC_W};
        tbl[19] = '{"bltz_undef",  32'h04600008, EXC_W};

        reset        = 1'b1;
        ifc.if_valid = 1'b0;
        ifc.instr    = '0;
        ifc.pc_plus  = '0;
        ifc.irq      = '0;
        ifc.stall    = 1'b0;
        ifc.flush    = 1'b0;
        step();
        step();
        check("reset_word", 64'(act_word()), 64'(0));
        check("reset_ack", 64'(ifc.irq_ack), 64'(0));
        check("reset_pc", 64'(ifc.ex_pc_plus), 64'(0));
        reset = 1'b0;

        // Decode table in kernel mode: undefined entries trap, the next kernel entry resumes.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].instr, PC_KERN);
            step();
            check({"vec_", tbl[i].name}, 64'(act_word()), 64'(tbl[i].exp));
        end

        // Reserved/undefined in user mode, then squash until kernel PC arrives.
        drive(I_ADD, PC_KERN); step();
        check("seqA_kernel_add", 64'(act_word()), 64'(ADD_W));
        check("seqA_ex_pc_plus", 64'(ifc.ex_pc_plus), 64'(PC_KERN));
        drive(I_BAD, PC_USER); step();
        check("seqA_exception", 64'(act_word()), 64'(EXC_W));
        drive(I_ADD, PC_USER); step();
        check("seqA_squash1", 64'(act_word()), 64'(0));
        step();
        check("seqA_squash2", 64'(act_word()), 64'(0));
        drive(I_ADD, PC_KERN); step();
        check("seqA_handler", 64'(act_word()), 64'(ADD_W));
        drive(I_ADD, PC_USER); step();
        check("seqA_user_run", 64'(act_word()), 64'(ADD_W));

        // Two lines rise together: lowest wins, the other is taken after return.
        ifc.irq = 4'b0110; step();
        check("seqB_edge_cycle", 64'(act_word()), 64'(ADD_W));
        check("seqB_edge_ack", 64'(ifc.irq_ack), 64'(0));
        step();
        check("seqB_trap1", 64'(act_word()), 64'(trap_w(4'd2)));
        check("seqB_ack1", 64'(ifc.irq_ack), 64'(4'b0010));
        step();
        check("seqB_squash", 64'(act_word()), 64'(0));
        check("seqB_squash_ack", 64'(ifc.irq_ack), 64'(0));
        drive(I_ADD, PC_KERN); step();
        check("seqB_handler", 64'(act_word()), 64'(ADD_W));
        drive(I_ADD, PC_USER); step();
        check("seqB_trap2", 64'(act_word()), 64'(trap_w(4'd3)));
        check("seqB_ack2", 64'(ifc.irq_ack), 64'(4'b0100));
        drive(I_ADD, PC_KERN); ifc.irq = 4'b0000; step();
        check("seqB_return", 64'(act_word()), 64'(ADD_W));

        // Edge in kernel mode is masked; stall holds it off; first free user cycle traps.
        ifc.irq = 4'b0001; step();
        check("seqC_kernel1", 64'(act_word()), 64'(ADD_W));
        step();
        check("seqC_kernel2", 64'(act_word()), 64'(ADD_W));
        check("seqC_kernel_ack", 64'(ifc.irq_ack), 64'(0));
        drive(I_ADD, PC_USER); ifc.stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            check($sformatf("seqC_stall%0d", s), 64'({ifc.irq_ack, act_word()}), 64'(0));
        end
        ifc.stall = 1'b0; step();
        check("seqC_trap", 64'(act_word()), 64'(trap_w(4'd1)));
        check("seqC_ack", 64'(ifc.irq_ack), 64'(4'b0001));
        drive(I_ADD, PC_KERN); ifc.irq = 4'b0000; step();
        check("seqC_return", 64'(act_word()), 64'(ADD_W));

        // Flush beats a pending interrupt without consuming it.
        ifc.irq = 4'b0001; step();
        check("seqD_pend_set", 64'(act_word()), 64'(ADD_W));
        drive(I_ADD, PC_USER); ifc.flush = 1'b1; step();
        check("seqD_flush", 64'(act_word()), 64'(0));
        check("seqD_flush_ack", 64'(ifc.irq_ack), 64'(0));
        ifc.flush = 1'b0; step();
        check("seqD_trap", 64'(act_word()), 64'(trap_w(4'd1)));
        check("seqD_ack", 64'(ifc.irq_ack), 64'(4'b0001));
        drive(I_ADD, PC_KERN); ifc.irq = 4'b0000; step();
        check("seqD_return", 64'(act_word()), 64'(ADD_W));

        // Enter TRAP via a kernel undefined instruction while line 0 is pending, then reset.
        ifc.irq = 4'b0001; step();
        drive(I_BAD, PC_KERN); step();
        check("seqE_exception", 64'(act_word()), 64'(EXC_W));
        #2 reset = 1'b1;
        #1;
        check("seqE_async_word", 64'(act_word()), 64'(0));
        check("seqE_async_ack", 64'(ifc.irq_ack), 64'(0));
        check("seqE_async_pc", 64'(ifc.ex_pc_plus), 64'(0));
        ifc.irq = 4'b0000;
        drive(I_ADD, PC_USER);
        step();
        reset = 1'b0;
        step();
        check("seqE_user1", 64'({ifc.irq_ack, act_word()}), 64'(ADD_W));
        step();
        check("seqE_user2", 64'({ifc.irq_ack, act_word()}), 64'(ADD_W));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
